seq_divider: RTL and testbench

- Iterative restoring unsigned divider that computes quotient and remainder, one quotient bit per clock.
- Companion to the team's segmented 8x8 multiplier path. It undoes the product: given a 16-bit value and an 8-bit divisor it recovers the other operand.
- Uses valid/ready handshakes on both input and output, so it can sit behind the multiplier in self-check and inverse-scaling datapaths.

---
 rtl/seq_divider.sv | 132 +++++++++++++
 tb/tb_seq_divider.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Iterative restoring unsigned divider. Produces one quotient bit
//            per clock and returns quotient and remainder through a
//            valid/ready output handshake. It recovers the second operand of
//            a product formed by the companion multiplier path.
// Ports    : clk          rising-edge clock
//            rst          asynchronous, active-high reset
//            in_valid     operands presented
//            in_ready     divider can accept operands (idle)
//            dividend     unsigned dividend, DIVIDEND_W bits
//            divisor      unsigned divisor, DIVISOR_W bits
//            out_valid    result valid
//            out_ready    consumer accepts result
//            quotient     unsigned quotient, DIVIDEND_W bits
//            remainder    unsigned remainder, DIVISOR_W bits
//            div_by_zero  divisor was zero for the current result
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int c_CNT_W = $clog2(DIVIDEND_W + 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_count;
    // Holds the not-yet-consumed dividend bits at the top and the quotient
    // bits already produced at the bottom; one bit migrates per iteration.
    logic [DIVIDEND_W-1:0] r_work;
    // Partial remainder is always < divisor between iterations, so it fits
    // in DIVISOR_W bits; only the shifted value needs the extra bit.
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_dbz;

    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W:0]    w_diff;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_rem_next;
    logic [DIVIDEND_W-1:0] w_work_next;

    assign w_shift = {r_rem, r_work[DIVIDEND_W-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};
    // w_shift <= 2*divisor-1, so a borrow always lands in the top bit:
    // top bit clear means the trial subtraction succeeded.
    assign w_ge        = ~w_diff[DIVISOR_W];
    assign w_rem_next  = w_ge ? w_diff[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
    assign w_work_next = {r_work[DIVIDEND_W-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_count     <= '0;
            r_work      <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            // No iterations needed: saturated quotient result.
                            r_state     <= c_S_DONE;
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state   <= c_S_BUSY;
                            r_count   <= c_CNT_W'(DIVIDEND_W);
                            r_work    <= dividend;
                            r_divisor <= divisor;
                            r_rem     <= '0;
                            r_dbz     <= 1'b0;
                        end
                    end
                end
                c_S_BUSY: begin
                    r_work  <= w_work_next;
                    r_rem   <= w_rem_next;
                    r_count <= r_count - c_CNT_W'(1);
                    // Result registers only change on the final iteration so
                    // the previous result stays visible while busy.
                    if (r_count == c_CNT_W'(1)) begin
                        r_state     <= c_S_DONE;
                        r_quotient  <= w_work_next;
                        r_remainder <= w_rem_next;
                    end
                end
                c_S_DONE: begin
                    if (out_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == c_S_IDLE);
    assign out_valid   = (r_state == c_S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider: directed vector table plus
//            hand-written multi-cycle sequences (backpressure, ignored
//            in_valid, reset mid-division) and random operand pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_total;
    int n_bad;

    seq_divider #(
        .DIVIDEND_W (16),
        .DIVISOR_W  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Presents operands on a falling edge, lets the next rising edge accept
    // them, and returns on the following falling edge with in_valid low and
    // the operand pins scrambled.
    task automatic accept(input logic [15:0] a, input logic [7:0] b);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Counts rising edges until out_valid is seen, bounded.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] q,
                                input logic [7:0] r, input logic z);
        chk({tag, "_quotient"}, {16'd0, quotient}, {16'd0, q});
        chk({tag, "_remainder"}, {24'd0, remainder}, {24'd0, r});
        chk({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, z});
    endtask

    // Holds out_ready low for 'stall' cycles checking the result is held,
    // then transfers it and checks the single idle cycle that follows.
    task automatic recv(input logic [15:0] q, input logic [7:0] r, input logic z,
                        input int stall);
        for (int i = 0; i < stall; i++) begin
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_result("stall", q, r, z);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("after_xfer_out_valid", {31'd0, out_valid}, 32'd0);
        chk("after_xfer_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_xfer_quotient_held", {16'd0, quotient}, {16'd0, q});
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        int a;
        int b;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;

        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0]  = '{16'd1000,  8'd7,   16'd142,    8'd6,  1'b0};
        vecs[1]  = '{16'hFFFF,  8'hFF,  16'h0101,   8'd0,  1'b0};
        vecs[2]  = '{16'hFFFF,  8'd1,   16'hFFFF,   8'd0,  1'b0};
        vecs[3]  = '{16'd5,     8'd9,   16'd0,      8'd5,  1'b0};
        vecs[4]  = '{16'd0,     8'd37,  16'd0,      8'd0,  1'b0};
        vecs[5]  = '{16'd1234,  8'd0,   16'hFFFF,   8'd0,  1'b1};
        vecs[6]  = '{16'd20,    8'd4,   16'd5,      8'd0,  1'b0};
        vecs[7]  = '{16'd200,   8'd3,   16'd66,     8'd2,  1'b0};
        vecs[8]  = '{16'd60000, 8'd250, 16'd240,    8'd0,  1'b0};
        vecs[9]  = '{16'd12345, 8'd123, 16'd100,    8'd45, 1'b0};
        vecs[10] = '{16'd255,   8'd16,  16'd15,     8'd15, 1'b0};
        vecs[11] = '{16'd0,     8'd0,   16'hFFFF,   8'd0,  1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result("rst", 16'd0, 8'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table; latency counted in rising edges after the accept edge
        for (int i = 0; i < 12; i++) begin
            accept(vecs[i].dvd, vecs[i].dvs);
            wait_out(lat);
            chk("latency", lat, vecs[i].z ? 32'd0 : 32'd16);
            check_result("vec", vecs[i].q, vecs[i].r, vecs[i].z);
            recv(vecs[i].q, vecs[i].r, vecs[i].z, i % 3);
        end

        // Backpressure: 5 stalled cycles with the result held
        accept(16'd1000, 8'd7);
        wait_out(lat);
        chk("bp_latency", lat, 32'd16);
        recv(16'd142, 8'd6, 1'b0, 5);

        // in_valid pulses during BUSY and DONE are ignored
        accept(16'd500, 8'd6);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd999;
        divisor  = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        wait_out(lat);
        chk("ign_latency", lat, 32'd14);
        check_result("ign", 16'd83, 8'd2, 1'b0);
        in_valid = 1'b1;
        dividend = 16'd7;
        divisor  = 8'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check_result("ign_done", 16'd83, 8'd2, 1'b0);
        recv(16'd83, 8'd2, 1'b0, 1);

        // Reset after 8 iterations of 200/3
        accept(16'd200, 8'd3);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result("midrst", 16'd0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        accept(16'd200, 8'd3);
        wait_out(lat);
        chk("postrst_latency", lat, 32'd16);
        check_result("postrst", 16'd66, 8'd2, 1'b0);
        recv(16'd66, 8'd2, 1'b0, 0);

        // Random operands against an arithmetic reference, random stalls
        for (int k = 0; k < 1000; k++) begin
            a = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 15) == 0)
                b = 0;
            else if ($urandom_range(0, 3) == 0)
                b = int'($urandom_range(1, 4));
            else
                b = int'($urandom_range(1, 255));
            if (b == 0) begin
                eq = 16'hFFFF;
                er = 8'd0;
                ez = 1'b1;
            end else begin
                eq = 16'(a / b);
                er = 8'(a % b);
                ez = 1'b0;
            end
            accept(16'(a), 8'(b));
            wait_out(lat);
            chk("rnd_latency", lat, ez ? 32'd0 : 32'd16);
            check_result("rnd", eq, er, ez);
            recv(eq, er, ez, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
